// File: rtl/qadd.sv
// qadd: signed-magnitude fixed-point adder with one register stage.
// Operands and result use bit N-1 as the sign and bits N-2:0 as the magnitude.
// Same-sign sums saturate to the largest magnitude and raise overflow.
// Opposite-sign operands subtract the smaller magnitude from the larger.
// A zero result is always given a positive sign.
module qadd #(
  parameter int Q = 23,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         out_valid,
  output logic         overflow
);

  localparam int MW = N - 1;  // magnitude width

  // Q only describes how the bits are read as a number. It must still leave
  // room inside the magnitude field, so an impossible format stops elaboration.
  if ((Q < 0) || (Q > MW)) begin : g_q_out_of_range
    $error("qadd: Q must lie in 0..N-1");
  end

  // Operand fields
  logic          sa;
  logic          sb;
  logic [MW-1:0] ma;
  logic [MW-1:0] mb;

  // Intermediate arithmetic
  logic [N-1:0]  sum_wide;     // ma + mb with room for the carry
  logic          a_ge_b;
  logic [MW-1:0] diff_mag;     // |ma - mb|
  logic          diff_sign;

  // Next-state values for the output register
  logic [MW-1:0] mag_next;
  logic          sign_next;
  logic          ovf_next;
  logic [N-1:0]  c_next;

  // Registered state
  logic [N-1:0]  c_reg;
  logic          out_valid_reg;
  logic          overflow_reg;

  assign sa = a[N-1];
  assign sb = b[N-1];
  assign ma = a[N-2:0];
  assign mb = b[N-2:0];

  // Compute the sum and the ordered difference of the two magnitudes.
  always_comb begin
    sum_wide  = {1'b0, ma} + {1'b0, mb};
    a_ge_b    = (ma >= mb);
    diff_mag  = '0;
    diff_sign = 1'b0;
    if (a_ge_b) begin
      diff_mag  = ma - mb;
      diff_sign = sa;
    end else begin
      diff_mag  = mb - ma;
      diff_sign = sb;
    end
  end

  // Pick add or subtract path, saturate carries, and force zero to be positive.
  always_comb begin
    mag_next  = '0;
    sign_next = 1'b0;
    ovf_next  = 1'b0;
    if (sa == sb) begin
      sign_next = sa;
      if (sum_wide[N-1]) begin
        mag_next = {MW{1'b1}};
        ovf_next = 1'b1;
      end else begin
        mag_next = sum_wide[N-2:0];
      end
    end else begin
      // The larger magnitude wins, so the difference never overflows.
      mag_next  = diff_mag;
      sign_next = diff_sign;
    end
    // Negative zero is never produced, whatever the input signs were.
    if (mag_next == '0) begin
      sign_next = 1'b0;
    end
    c_next = {sign_next, mag_next};
  end

  // Output register: load on a valid beat, hold value otherwise, clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg         <= '0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        c_reg        <= c_next;
        overflow_reg <= ovf_next;
      end
    end
  end

  assign c         = c_reg;
  assign out_valid = out_valid_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_qadd.sv
// Directed testbench for qadd with N=32, Q=23.
module tb_qadd;

  localparam int N = 32;
  localparam int Q = 23;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] c;
  logic         out_valid;
  logic         overflow;

  int tests_run;
  int tests_failed;

  qadd #(.Q(Q), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare all three outputs against expected values; one line per check.
  task automatic check(input string tag, input logic [N-1:0] exp_c,
                       input logic exp_ovf, input logic exp_valid);
    tests_run++;
    assert (c === exp_c && overflow === exp_ovf && out_valid === exp_valid)
    else begin
      tests_failed++;
      $error("FAIL %s: observed c=%h ovf=%b vld=%b expected c=%h ovf=%b vld=%b",
             tag, c, overflow, out_valid, exp_c, exp_ovf, exp_valid);
    end
    $display("[TB] %s: c=%h ovf=%b vld=%b", tag, c, overflow, out_valid);
  endtask

  // Present one operand pair at a falling edge, then check the result at the next.
  task automatic add_once(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] exp_c, input logic exp_ovf);
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    in_valid = 1'b0;
    a = '0;
    b = '0;
    check(tag, exp_c, exp_ovf, 1'b1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;

    // Reset state
    @(negedge clk);
    check("reset", 32'h0000_0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'h0000_0000, 1'b0, 1'b0);

    // Directed single additions
    add_once("pos_pos",        32'h00C0_0000, 32'h0120_0000, 32'h01E0_0000, 1'b0);
    add_once("pos_neg",        32'h0080_0000, 32'h8180_0000, 32'h8100_0000, 1'b0);
    add_once("neg_pos_swap",   32'h8180_0000, 32'h0080_0000, 32'h8100_0000, 1'b0);
    add_once("cancel",         32'h0080_0000, 32'h8080_0000, 32'h0000_0000, 1'b0);
    add_once("negzero_plus0",  32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    add_once("negzero_twice",  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
    add_once("neg_cancel",     32'h8000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0);
    add_once("b_larger_pos",   32'h8000_0002, 32'h0000_0005, 32'h0000_0003, 1'b0);
    add_once("b_larger_neg",   32'h0000_0002, 32'h8000_0005, 32'h8000_0003, 1'b0);
    add_once("max_no_ovf",     32'h7FFF_FFFE, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
    add_once("sat_pos",        32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    @(negedge clk);
    check("hold_after_sat", 32'h7FFF_FFFF, 1'b1, 1'b0);
    add_once("sat_neg",        32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);

    // Streaming: four back-to-back pairs, then idle
    @(negedge clk);
    in_valid = 1'b1; a = 32'h0000_0001; b = 32'h0000_0002;
    @(negedge clk);
    check("stream_0", 32'h0000_0003, 1'b0, 1'b1);
    a = 32'h8000_0010; b = 32'h8000_0020;
    @(negedge clk);
    check("stream_1", 32'h8000_0030, 1'b0, 1'b1);
    a = 32'h0000_0100; b = 32'h8000_0040;
    @(negedge clk);
    check("stream_2", 32'h0000_00C0, 1'b0, 1'b1);
    a = 32'h4000_0000; b = 32'h4000_0000;
    @(negedge clk);
    check("stream_3", 32'h7FFF_FFFF, 1'b1, 1'b1);
    in_valid = 1'b0; a = 32'h0000_1111; b = 32'h0000_2222;
    @(negedge clk);
    check("stream_idle", 32'h7FFF_FFFF, 1'b1, 1'b0);
    // Inputs changing while idle must not disturb the held result
    a = 32'h0123_4567; b = 32'h0000_0001;
    @(negedge clk);
    check("idle_hold", 32'h7FFF_FFFF, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a valid stream
    in_valid = 1'b1; a = 32'h0000_0010; b = 32'h0000_0020;
    @(negedge clk);
    check("pre_reset", 32'h0000_0030, 1'b0, 1'b1);
    a = 32'h0000_0007; b = 32'h0000_0008;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_held", 32'h0000_0000, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_release", 32'h0000_0000, 1'b0, 1'b0);
    add_once("first_after_reset", 32'h0000_0004, 32'h0000_0005, 32'h0000_0009, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
